// File: rtl/cubic_pkg.sv
// cubic_pkg: FSM state, frame phase constants and widths shared by the cubic feeder.
// Edge clamping is selected by CUBIC_FEEDER_EDGE_CLAMP_EN in cubic_feeder.
package cubic_pkg;
    typedef enum logic [1:0] {IDLE, FRAME, DRAIN} state_t;
    localparam logic [2:0] CYC_LOAD = 3'd0;
    localparam logic [2:0] CYC_LAST = 3'd4;
    localparam int SAMPLE_W = 8;
    localparam int FRAC_W = 8;
    localparam int XIN_W = 24;
endpackage

// File: rtl/cubic_pow.sv
// cubic_pow: packs the Q0.8 weights {x, x^2, x^3} with truncating products.
module cubic_pow import cubic_pkg::*; (
    input  logic [FRAC_W-1:0] frac,
    output logic [XIN_W-1:0]  weights
);
    logic [2*FRAC_W-1:0] sq;
    logic [2*FRAC_W-1:0] cu;
    logic [FRAC_W-1:0]   x2;
    logic [FRAC_W-1:0]   x3;
    always_comb begin
        sq = frac * frac;
        x2 = sq[2*FRAC_W-1:FRAC_W];
        cu = x2 * frac;
        x3 = cu[2*FRAC_W-1:FRAC_W];
        weights = {frac, x2, x3};
    end
endmodule

// File: rtl/cubic_feeder.sv
// cubic_feeder: fetches P(-1..2) around base_idx and streams them with weights to a cubic engine.
// Define CUBIC_FEEDER_EDGE_CLAMP_EN to clamp sample indices to [0, img_w-1]; otherwise they wrap mod 256.
module cubic_feeder import cubic_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          base_idx,
    input  logic [FRAC_W-1:0]   frac,
    input  logic [7:0]          img_w,
    output logic                mem_rd,
    output logic [7:0]          mem_addr,
    input  logic [SAMPLE_W-1:0] mem_data,
    output logic [XIN_W-1:0]    X_in,
    output logic [SAMPLE_W-1:0] P_in,
    output logic [2:0]          cycle_cnt,
    input  logic [SAMPLE_W-1:0] eng_out,
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] result
);
    state_t             state;
    logic [7:0]         base_q;
    logic [7:0]         a_base;
    logic [2:0]         a_cyc;
    logic [9:0]         a_sum;
    logic [7:0]         mem_idx;
    logic [XIN_W-1:0]   weights;
    logic               in_drain;
    logic               load;

    cubic_pow u_pow (.frac(frac), .weights(weights));

    assign in_drain = state == DRAIN;
    assign load = start && (state == IDLE || in_drain);
    // DRAIN overlaps phase 0 of a chained frame, so its read uses the live request
    assign a_base = in_drain ? base_idx : base_q;
    assign a_cyc = in_drain ? CYC_LOAD : cycle_cnt;
    assign a_sum = {2'b00, a_base} + {7'd0, a_cyc} - 10'd1;

`ifdef CUBIC_FEEDER_EDGE_CLAMP_EN
    logic [7:0] w_q;
    logic [7:0] a_w;
    always_ff @(posedge clk) begin
        if (!rst) w_q <= '0;
        else if (load) w_q <= img_w;
    end
    assign a_w = in_drain ? img_w : w_q;
    assign mem_idx = a_sum[9] ? 8'd0 : (a_sum > {2'b00, a_w - 8'd1}) ? a_w - 8'd1 : a_sum[7:0];
`else
    logic unused_w;
    assign unused_w = ^img_w;
    assign mem_idx = a_sum[7:0];
`endif

    assign mem_rd = (state == FRAME && cycle_cnt != CYC_LAST) || (in_drain && start);
    assign mem_addr = mem_rd ? mem_idx : 8'd0;
    assign P_in = (state == FRAME && cycle_cnt != CYC_LOAD) ? mem_data : '0;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cycle_cnt <= CYC_LOAD;
            base_q <= '0;
            X_in <= '0;
            done <= 1'b0;
            result <= '0;
        end else begin
            done <= in_drain;
            if (in_drain) result <= eng_out;
            if (load) begin
                base_q <= base_idx;
                X_in <= weights;
            end
            case (state)
                IDLE: state <= start ? FRAME : IDLE;
                FRAME: begin
                    state <= cycle_cnt == CYC_LAST ? DRAIN : FRAME;
                    cycle_cnt <= cycle_cnt == CYC_LAST ? CYC_LOAD : cycle_cnt + 3'd1;
                end
                default: begin
                    state <= start ? FRAME : IDLE;
                    cycle_cnt <= start ? CYC_LOAD + 3'd1 : CYC_LOAD;
                end
            endcase
        end
    end
endmodule
